// File: rtl/game_pkg.sv
// Shared sequencer types: FSM state encoding, screen_sel codes and the lives ceiling.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_PLAY     = 3'd1,
        ST_DYING    = 3'd2,
        ST_GAMEOVER = 3'd3,
        ST_WIN      = 3'd4
    } state_t;

    localparam logic [1:0] SCR_START    = 2'd0;
    localparam logic [1:0] SCR_PLAY     = 2'd1;
    localparam logic [1:0] SCR_GAMEOVER = 2'd2;
    localparam logic [1:0] SCR_WIN      = 2'd3;

    localparam logic [1:0] LIVES_MAX = 2'd3;

endpackage

// File: rtl/button_edge_detector.sv
// Two-flop synchroniser for an asynchronous button, followed by a registered
// rising-edge detector; the pulse appears three clocks after the press.
module button_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic rise
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], button};
            prev_q <= sync_q[1];
            rise   <= sync_q[1] & ~prev_q;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Game screen sequencer: START -> PLAY -> DYING/WIN -> GAMEOVER, stepped on frame ticks.
// Optional debug LED mirror enabled by defining SEQ_DEBUG_LEDS_EN.
//
// state    | meaning
// START    | title screen, waiting for a jump press
// PLAY     | game physics running, collecting death/level events
// DYING    | death animation for DEATH_FRAMES frames
// GAMEOVER | game-over screen for GAMEOVER_FRAMES frames
// WIN      | level complete, waiting for a jump press
module screen_sequencer
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int LIVES_INIT      = 3,
    parameter int DEATH_FRAMES    = 60,
    parameter int GAMEOVER_FRAMES = 180
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  int         row,
    input  int         column,
    input  logic       display_enable,
    input  logic       jump_button,
    input  logic       mario_dead,
    input  logic       level_done,
    output logic [1:0] screen_sel,
    output logic       game_run,
    output logic       game_reset,
    output logic [1:0] lives,
    output logic [9:0] leds
);

    localparam logic [1:0] LIVES_LOAD =
        (LIVES_INIT > int'(LIVES_MAX)) ? LIVES_MAX : 2'(LIVES_INIT);
    localparam logic [7:0] DEATH_LAST    = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] GAMEOVER_LAST = 8'(GAMEOVER_FRAMES - 1);

    state_t     state;
    logic [7:0] frame_cnt;
    logic       start_pend;
    logic       dead_pend;
    logic       done_pend;
    logic       jump_edge;
    logic       frame_tick;

    button_edge_detector u_jump (
        .clk    (vga_clock),
        .rst    (reset),
        .button (jump_button),
        .rise   (jump_edge)
    );

    assign frame_tick = display_enable && (row == SCREEN_HEIGHT - 1)
                        && (column == SCREEN_WIDTH - 1);

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state      <= ST_START;
            screen_sel <= SCR_START;
            game_run   <= 1'b0;
            game_reset <= 1'b0;
            lives      <= 2'd0;
            frame_cnt  <= 8'd0;
            start_pend <= 1'b0;
            dead_pend  <= 1'b0;
            done_pend  <= 1'b0;
        end else begin
            game_reset <= 1'b0;
            case (state)
                ST_START: begin
                    if (frame_tick && start_pend) begin
                        state      <= ST_PLAY;
                        screen_sel <= SCR_PLAY;
                        game_run   <= 1'b1;
                        game_reset <= 1'b1;
                        lives      <= LIVES_LOAD;
                        start_pend <= 1'b0;
                        frame_cnt  <= 8'd0;
                    end else if (jump_edge) begin
                        start_pend <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // A pulse landing on the tick cycle itself is still honoured.
                    if (frame_tick) begin
                        dead_pend <= 1'b0;
                        done_pend <= 1'b0;
                        if (done_pend || level_done) begin
                            state      <= ST_WIN;
                            screen_sel <= SCR_WIN;
                            game_run   <= 1'b0;
                            frame_cnt  <= 8'd0;
                        end else if (dead_pend || mario_dead) begin
                            state      <= ST_DYING;
                            screen_sel <= SCR_PLAY;
                            game_run   <= 1'b0;
                            frame_cnt  <= 8'd0;
                            lives      <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                        end
                    end else begin
                        if (mario_dead) dead_pend <= 1'b1;
                        if (level_done) done_pend <= 1'b1;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (frame_cnt == DEATH_LAST) begin
                            frame_cnt <= 8'd0;
                            if (lives == 2'd0) begin
                                state      <= ST_GAMEOVER;
                                screen_sel <= SCR_GAMEOVER;
                            end else begin
                                state      <= ST_PLAY;
                                screen_sel <= SCR_PLAY;
                                game_run   <= 1'b1;
                                game_reset <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_GAMEOVER: begin
                    if (frame_tick) begin
                        if (frame_cnt == GAMEOVER_LAST) begin
                            frame_cnt  <= 8'd0;
                            state      <= ST_START;
                            screen_sel <= SCR_START;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_WIN: begin
                    // The press that leaves WIN is consumed, so START waits for a fresh one.
                    if (frame_tick && start_pend) begin
                        state      <= ST_START;
                        screen_sel <= SCR_START;
                        start_pend <= 1'b0;
                        frame_cnt  <= 8'd0;
                    end else if (jump_edge) begin
                        start_pend <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_START;
                    screen_sel <= SCR_START;
                    game_run   <= 1'b0;
                    frame_cnt  <= 8'd0;
                end
            endcase
        end
    end

`ifdef SEQ_DEBUG_LEDS_EN
    assign leds = {3'b000, dead_pend, start_pend, lives, state};
`else
    assign leds = 10'd0;
`endif

endmodule
